xor_accum_bank: RTL

- Parametrised, clocked successor to the quad-XOR TTL gate model.
- Provides CHANNELS independent XOR/XNOR lanes of WIDTH bits. Each lane is registered and can either load fresh (a ^ b) or accumulate into its previous result.
- Also provides per-lane parity, a saturating word counter and a valid handshake.
- Keeps the TTL supply-pin semantics: logic advances only when vcc=1 and gnd=0.

---
 rtl/xor_accum_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/xor_accum_bank.sv
// xor_accum_bank: CHANNELS registered XOR/XNOR lanes of WIDTH bits, each able to
// load a fresh (a ^ b) or fold it into its previous result. Also provides
// per-lane parity, a saturating count of accepted words and a busy flag.
// Nothing advances unless the supply pins read vcc=1, gnd=0.
//
// Handshake: a word is accepted on every rising edge where the block is powered,
// not recovering from NOPWR, and in_valid=1; there is no ready/backpressure.
// out_valid is high for exactly the one cycle following an accepted word, and
// y/parity/count in that cycle reflect that word.
//
// dbg_state encoding: 0 = IDLE, 1 = RUN, 2 = NOPWR.
module xor_accum_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vcc,
  input  logic                      gnd,
  input  logic                      in_valid,
  input  logic                      accum,
  input  logic                      xnor_mode,
  input  logic                      clear,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic [CHANNELS-1:0]       parity,
  output logic                      out_valid,
  output logic [CNT_W-1:0]          count,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    NOPWR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                      state_q, state_d;
  logic [CHANNELS*WIDTH-1:0]   y_q, y_d;
  logic [CHANNELS-1:0]         par_q, par_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        ov_q, ov_d;

  logic                        powered;
  logic [WIDTH-1:0]            lane_w;
  logic [CHANNELS*WIDTH-1:0]   lane_nxt;
  logic [CHANNELS-1:0]         lane_par;
  logic [CNT_W-1:0]            cnt_inc;

  // Per-lane datapath: fresh XOR, optional fold into the old lane value
  // (suppressed by clear, which wipes history first), then optional inversion.
  always_comb begin
    lane_w   = '0;
    lane_nxt = '0;
    lane_par = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_w = a[k*WIDTH +: WIDTH] ^ b[k*WIDTH +: WIDTH];
      if (accum && !clear) lane_w = lane_w ^ y_q[k*WIDTH +: WIDTH];
      if (xnor_mode) lane_w = ~lane_w;
      lane_nxt[k*WIDTH +: WIDTH] = lane_w;
      lane_par[k]                = ^lane_w;
    end
  end

  // Saturating increment: the counter parks at all-ones and never wraps.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  // Next-state and register updates. Unknown supply pins fall into the
  // unpowered branch. The edge that leaves NOPWR only lands in IDLE and
  // accepts nothing, so a recovered block always restarts from IDLE.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    powered = vcc & ~gnd;
    if (powered) begin
      if (state_q == NOPWR) begin
        state_d = IDLE;
      end else if (in_valid) begin
        y_d     = lane_nxt;
        par_d   = lane_par;
        cnt_d   = clear ? CNT_ONE : cnt_inc;
        ov_d    = 1'b1;
        state_d = RUN;
      end else if (clear) begin
        y_d     = '0;
        par_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else begin
      state_d = NOPWR;
    end
  end

  // State and datapath registers; reset discards all accumulated history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  assign y         = y_q;
  assign parity    = par_q;
  assign count     = cnt_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == RUN);
  assign dbg_state = state_q;

endmodule
